// File: rtl/trng_batch_collector.sv
// Collects a serial entropy bit stream (XOR of channels or one selected channel) into
// DATA_WIDTH-bit words and writes BATCH_SIZE of them to memory. Define RCT_EN for the repetition-count health test.
module trng_batch_collector #(
    parameter int NUM_CH         = 4,
    parameter int DATA_WIDTH     = 8,
    parameter int BATCH_SIZE     = 1000,
    parameter int MEM_ADDR_WIDTH = $clog2(BATCH_SIZE),
    parameter int RCT_CUTOFF     = 32,
    parameter int CH_SEL_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                      iClk,
    input  logic                      iRst,
    input  logic                      iStart,
    input  logic                      iMode,
    input  logic [CH_SEL_W-1:0]       iChSel,
    input  logic [NUM_CH-1:0]         iBits,
    input  logic                      iValid,
    output logic                      oMemWe,
    output logic [MEM_ADDR_WIDTH-1:0] oMemAddr,
    output logic [DATA_WIDTH-1:0]     oMemDin,
    output logic                      oBusy,
    output logic                      oDone,
    output logic                      oHealthFail
);

    localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, COLLECT, DONE, FAIL} state_t;

    state_t                    state, state_n;
    logic [BIT_W-1:0]          bit_cnt;
    logic [MEM_ADDR_WIDTH-1:0] word_idx;
    logic [DATA_WIDTH-2:0]     shreg;
    logic [DATA_WIDTH-1:0]     shreg_n;
    logic                      sel_bit, take, word_end, last_word, start_ok, trip;

    // Out-of-range channel indices fall back to channel 0
    always_comb begin
        sel_bit = ^iBits;
        if (iMode) begin
            sel_bit = iBits[0];
            for (int i = 1; i < NUM_CH; i++)
                if (iChSel == CH_SEL_W'(i)) sel_bit = iBits[i];
        end
    end

    always_comb begin
        take      = (state == COLLECT) && iValid;
        word_end  = take && (bit_cnt == BIT_W'(DATA_WIDTH - 1));
        last_word = (word_idx == MEM_ADDR_WIDTH'(BATCH_SIZE - 1));
        start_ok  = iStart && (state != COLLECT);
        shreg_n   = {shreg, sel_bit};
    end

`ifdef RCT_EN
    localparam int RUN_W = $clog2(RCT_CUTOFF + 1);

    logic [RUN_W-1:0] run_cnt, run_next;
    logic             run_bit;

    always_comb begin
        run_next = RUN_W'(1);
        if (run_cnt != '0 && sel_bit == run_bit) run_next = run_cnt + RUN_W'(1);
        trip = take && (run_next == RUN_W'(RCT_CUTOFF));
    end

    always_ff @(posedge iClk) begin
        if (iRst || start_ok) begin
            run_cnt <= '0;
            run_bit <= 1'b0;
        end else if (take) begin
            run_cnt <= run_next;
            run_bit <= sel_bit;
        end
    end

    assign oHealthFail = (state == FAIL);
`else
    logic unused_rct_cutoff;
    assign unused_rct_cutoff = (RCT_CUTOFF != 0);
    assign trip        = 1'b0;
    assign oHealthFail = 1'b0;
`endif

    always_ff @(posedge iClk) begin
        if (iRst) state <= IDLE;
        else      state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            COLLECT: begin
                if (trip)                       state_n = FAIL;
                else if (word_end && last_word) state_n = DONE;
            end
            default: if (iStart) state_n = COLLECT;
        endcase
    end

    assign oBusy = (state == COLLECT);
    assign oDone = (state == DONE);

    // The final write lands in the same cycle DONE is entered
    always_ff @(posedge iClk) begin
        if (iRst) begin
            bit_cnt  <= '0;
            word_idx <= '0;
            shreg    <= '0;
            oMemWe   <= 1'b0;
            oMemAddr <= '0;
            oMemDin  <= '0;
        end else begin
            oMemWe <= 1'b0;
            if (start_ok) begin
                bit_cnt  <= '0;
                word_idx <= '0;
                shreg    <= '0;
                oMemAddr <= '0;
                oMemDin  <= '0;
            end else if (take) begin
                shreg <= shreg_n[DATA_WIDTH-2:0];
                if (word_end) begin
                    bit_cnt <= '0;
                    if (!trip) begin
                        oMemWe   <= 1'b1;
                        oMemDin  <= shreg_n;
                        oMemAddr <= word_idx;
                        if (!last_word) word_idx <= word_idx + MEM_ADDR_WIDTH'(1);
                    end
                end else begin
                    bit_cnt <= bit_cnt + BIT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_trng_batch_collector.sv
// Bench for trng_batch_collector: word-level model compared every cycle plus literal scenario checks.
module tb_trng_batch_collector;

    localparam int NUM_CH = 4;
    localparam int DW     = 8;
    localparam int BS     = 1000;
    localparam int AW     = 10;
    localparam int CSW    = 2;
    localparam int RCT    = 32;

    logic          iClk = 1'b0;
    logic          iRst, iStart, iMode, iValid;
    logic [CSW-1:0] iChSel;
    logic [NUM_CH-1:0] iBits;
    logic          oMemWe;
    logic [AW-1:0] oMemAddr;
    logic [DW-1:0] oMemDin;
    logic          oBusy, oDone, oHealthFail;

    always #5 iClk = ~iClk;

    trng_batch_collector dut (
        .iClk(iClk), .iRst(iRst), .iStart(iStart), .iMode(iMode), .iChSel(iChSel),
        .iBits(iBits), .iValid(iValid), .oMemWe(oMemWe), .oMemAddr(oMemAddr),
        .oMemDin(oMemDin), .oBusy(oBusy), .oDone(oDone), .oHealthFail(oHealthFail)
    );

    int checks = 0, failures = 0, cyc_n = 0;
    bit chk_en = 1'b0;

    // model: phase 0 idle, 1 collecting, 2 batch complete, 3 health failure
    int   phase = 0, nbits = 0, acc = 0, nwords = 0, run = 0, runbit = 0;
    logic e_we = 1'b0, e_busy = 1'b0, e_done = 1'b0, e_hf = 1'b0;
    int   e_addr = 0, e_din = 0;

    int wr_addr[$], wr_din[$], wr_cyc[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc_n);
        end
    endtask

    always @(negedge iClk) begin
        cyc_n++;
        if (chk_en) begin
            chk("we", oMemWe, e_we);
            chk("busy", oBusy, e_busy);
            chk("done", oDone, e_done);
            chk("health", oHealthFail, e_hf);
            if (e_we) begin
                chk("addr", oMemAddr, e_addr);
                chk("din", oMemDin, e_din);
            end
        end
        if (oMemWe === 1'b1) begin
            wr_addr.push_back(int'(oMemAddr));
            wr_din.push_back(int'(oMemDin));
            wr_cyc.push_back(cyc_n);
        end
    end

    // Apply one cycle of inputs and advance the model to the outputs expected after the edge
    task automatic cyc(input logic r, input logic s, input logic m, input logic [CSW-1:0] cs,
                       input logic [NUM_CH-1:0] b, input logic v);
        int bit_v;
        bit tripped;
        @(negedge iClk);
        #1;
        iRst = r; iStart = s; iMode = m; iChSel = cs; iBits = b; iValid = v;
        e_we = 1'b0;
        if (r) begin
            phase = 0; e_addr = 0; e_din = 0;
        end else if (phase != 1) begin
            if (s) begin
                phase = 1; nbits = 0; acc = 0; nwords = 0; run = 0;
            end
        end else if (v) begin
            if (m) bit_v = (int'(cs) < NUM_CH) ? int'(b[cs]) : int'(b[0]);
            else   bit_v = int'(^b);
            acc = ((acc * 2) + bit_v) % (1 << DW);
            nbits++;
            tripped = 1'b0;
`ifdef RCT_EN
            run = (run > 0 && bit_v == runbit) ? run + 1 : 1;
            runbit = bit_v;
            if (run == RCT) tripped = 1'b1;
`endif
            if (tripped) phase = 3;
            else if (nbits == DW) begin
                e_we = 1'b1; e_din = acc; e_addr = nwords;
                nwords++; nbits = 0; acc = 0;
                if (nwords == BS) phase = 2;
            end
        end
        e_busy = (phase == 1);
        e_done = (phase == 2);
        e_hf   = (phase == 3);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
    endtask

    task automatic clear_wr();
        wr_addr.delete(); wr_din.delete(); wr_cyc.delete();
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_we"}, oMemWe, 0);
        chk({nm, "_addr"}, oMemAddr, 0);
        chk({nm, "_din"}, oMemDin, 0);
        chk({nm, "_busy"}, oBusy, 0);
        chk({nm, "_done"}, oDone, 0);
        chk({nm, "_hf"}, oHealthFail, 0);
    endtask

    initial begin
        logic [7:0] pat;
        logic       pb;
        int         nb2, nff;
        logic [NUM_CH-1:0] rb;
        pat = 8'b10110010;
        iRst = 1'b1; iStart = 1'b0; iMode = 1'b0; iChSel = '0; iBits = '0; iValid = 1'b0;

        // Reset state
        cyc(1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
        chk_en = 1'b1;
        idle(1);
        chk_zero("reset");

        // Scenario 1: channel 2 carries 10110010 repeatedly, other channels inverted
        clear_wr();
        cyc(1'b0, 1'b1, 1'b1, 2'd2, '0, 1'b0);
        for (int k = 0; k < BS * DW; k++) begin
            pb = pat[7 - (k % 8)];
            cyc(1'b0, 1'b0, 1'b1, 2'd2, {~pb, pb, ~pb, ~pb}, 1'b1);
        end
        for (int k = 0; k < 4; k++) cyc(1'b0, 1'b0, 1'b1, 2'd2, 4'b0100, 1'b1);
        idle(2);
        nb2 = 0;
        foreach (wr_din[i]) if (wr_din[i] == 8'hB2) nb2++;
        chk("s1_writes", wr_din.size(), BS);
        chk("s1_b2_words", nb2, BS);
        chk("s1_first_addr", (wr_addr.size() > 0) ? wr_addr[0] : -1, 0);
        chk("s1_last_addr", (wr_addr.size() > 0) ? wr_addr[wr_addr.size()-1] : -1, BS - 1);
        chk("s1_done", oDone, 1);
        chk("s1_busy", oBusy, 0);

        // Scenario 2: XOR of 0111 is 1, valid every other cycle
        clear_wr();
        cyc(1'b0, 1'b1, 1'b0, 2'd0, '0, 1'b0);
        chk("s2_done_cleared", oDone, 1);
        for (int k = 0; k < 64; k++) cyc(1'b0, 1'b0, 1'b0, 2'd0, 4'b0111, (k % 2) == 0);
        idle(2);
        chk("s2_done_low", oDone, 0);
        chk("s2_first_ff", (wr_din.size() > 0) ? wr_din[0] : -1, 8'hFF);
        chk("s2_spacing", (wr_cyc.size() > 1) ? wr_cyc[1] - wr_cyc[0] : -1, 16);
`ifdef RCT_EN
        chk("s2_writes", wr_din.size(), 3);
`else
        chk("s2_writes", wr_din.size(), 4);
`endif

        // Scenario 3: reset overrides start, then mid-batch abort at word 500
        cyc(1'b1, 1'b1, 1'b0, '0, '0, 1'b0);
        idle(1);
        chk("s3_rst_over_start_busy", oBusy, 0);
        clear_wr();
        cyc(1'b0, 1'b1, 1'b1, 2'd1, '0, 1'b0);
        for (int k = 0; k < 500 * DW + 3; k++) begin
            rb = NUM_CH'($urandom);
            cyc(1'b0, 1'b0, 1'b1, 2'd1, rb, 1'b1);
        end
        cyc(1'b1, 1'b0, 1'b1, 2'd1, 4'b1111, 1'b1);
        cyc(1'b0, 1'b0, 1'b1, 2'd1, 4'b1111, 1'b1);
        chk_zero("s3_abort");
        idle(10);
        chk("s3_writes_before_abort", wr_din.size(), 500);
        clear_wr();
        cyc(1'b0, 1'b1, 1'b1, 2'd3, '0, 1'b0);
        for (int k = 0; k < DW; k++) cyc(1'b0, 1'b0, 1'b1, 2'd3, 4'b1000, 1'b1);
        idle(2);
        chk("s3_restart_addr", (wr_addr.size() > 0) ? wr_addr[0] : -1, 0);
        chk("s3_restart_din", (wr_din.size() > 0) ? wr_din[0] : -1, 8'hFF);

        // Scenario 4: start pulse mid-batch ignored; channel select changes every bit
        cyc(1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
        clear_wr();
        cyc(1'b0, 1'b1, 1'b1, 2'd0, '0, 1'b0);
        for (int k = 0; k < 14 * DW; k++) begin
            rb = NUM_CH'($urandom);
            cyc(1'b0, (k == 10 * DW + 3), 1'b1, CSW'(k % 4), rb, 1'b1);
        end
        idle(2);
        chk("s4_writes", wr_addr.size(), 14);
        chk("s4_addr11", (wr_addr.size() > 11) ? wr_addr[11] : -1, 11);
        chk("s4_addr12", (wr_addr.size() > 12) ? wr_addr[12] : -1, 12);

        // Scenario 5/6: 32 consecutive valid ones
        cyc(1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
        clear_wr();
        cyc(1'b0, 1'b1, 1'b0, 2'd0, '0, 1'b0);
        for (int k = 0; k < RCT; k++) cyc(1'b0, 1'b0, 1'b0, 2'd0, 4'b0001, 1'b1);
        idle(3);
        nff = 0;
        foreach (wr_din[i]) if (wr_din[i] == 8'hFF) nff++;
        chk("s56_done", oDone, 0);
`ifdef RCT_EN
        chk("s5_writes", wr_din.size(), 3);
        chk("s5_ff_words", nff, 3);
        chk("s5_health", oHealthFail, 1);
        chk("s5_busy", oBusy, 0);
        cyc(1'b0, 1'b1, 1'b0, 2'd0, '0, 1'b0);
        idle(1);
        chk("s5_restart_health", oHealthFail, 0);
        chk("s5_restart_busy", oBusy, 1);
`else
        chk("s6_writes", wr_din.size(), 4);
        chk("s6_ff_words", nff, 4);
        chk("s6_health", oHealthFail, 0);
        chk("s6_busy", oBusy, 1);
`endif
        idle(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
